// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: valid/ready pipeline stage register with a two-entry skid
// buffer, flush, and a saturating stall counter.
//
// Ports:
//   clock, rst (async, active-low), flush
//   in_valid / in_ready / in_data    : upstream handshake and payload
//   out_valid / out_ready / out_data : downstream handshake and head payload
//   occupancy                        : held entries (0..2)
//   stall_cnt                        : saturating count of out_valid & ~out_ready
//
// Macro PIPE_STAGE_DATA_CLR_EN: when defined, payload registers reset to 0
// and load 0 on flush; otherwise they have no reset and flush leaves them.
module pipe_skid_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;

    logic in_xfer;
    logic out_xfer;
    logic ld_main_in;
    logic ld_main_skid;
    logic ld_skid;

    // Handshake outputs come from registered state only, so out_ready
    // never reaches in_ready combinationally.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign occupancy = state;
    assign out_data  = main_q;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            // Inputs in this cycle are dropped; the head may still leave.
            state_nx = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        state_nx   = ONE;
                        ld_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        ld_main_in = 1'b1;
                    end else if (in_xfer) begin
                        state_nx = TWO;
                        ld_skid  = 1'b1;
                    end else if (out_xfer) begin
                        state_nx = EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        state_nx     = ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_nx = EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_DATA_CLR_EN
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main_in) begin
                main_q <= in_data;
            end else if (ld_main_skid) begin
                main_q <= skid_q;
            end
            if (ld_skid) begin
                skid_q <= in_data;
            end
        end
    end
`else
    always_ff @(posedge clock) begin
        if (ld_main_in) begin
            main_q <= in_data;
        end else if (ld_main_skid) begin
            main_q <= skid_q;
        end
        if (ld_skid) begin
            skid_q <= in_data;
        end
    end
`endif

    // Flush does not touch the counter; only reset clears it.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage: directed and random checks of pipe_skid_stage
// against a queue-based reference of the stage contents.
module tb_pipe_skid_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clock;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    logic [DATA_W-1:0] sb[$];
    int stall_m;
    int n_assert;
    int n_fail;

    pipe_skid_stage #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive after negedge, check registered outputs, then
    // advance the reference at the rising edge.
    task automatic step(input logic fl, input logic iv,
                        input logic [DATA_W-1:0] d, input logic ordy);
        logic ov;
        logic acc;
        logic [DATA_W-1:0] head;
        @(negedge clock);
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        ov  = (sb.size() > 0);
        acc = iv && (sb.size() < 2);
        chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(ov));
        chk("occupancy", 32'(occupancy), 32'(sb.size()));
        chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
        if (ov && ordy) begin
            head = sb.pop_front();
            chk("out_data", out_data, head);
        end
        @(posedge clock);
        if (ov && !ordy && stall_m < CMAX) stall_m++;
        if (fl) sb.delete();
        else if (acc) sb.push_back(d);
    endtask

    task automatic check_reset();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`ifdef PIPE_STAGE_DATA_CLR_EN
        chk("rst_out_data", out_data, 32'd0);
`endif
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        stall_m   = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check_reset();
        @(negedge clock);
        rst = 1'b1;

        // Streaming with no back-pressure
        for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, DATA_W'(i), 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Back-pressure fills the skid, then drains in order
        step(1'b0, 1'b1, 32'hA, 1'b0);
        step(1'b0, 1'b1, 32'hB, 1'b0);
        step(1'b0, 1'b1, 32'hC, 1'b0);
        step(1'b0, 1'b1, 32'hC, 1'b1);
        step(1'b0, 1'b1, 32'hC, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Flush in TWO with concurrent input, head delivered
        step(1'b0, 1'b1, 32'h11, 1'b0);
        step(1'b0, 1'b1, 32'h22, 1'b0);
        step(1'b1, 1'b1, 32'hDD, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        // Flush with input while EMPTY stays EMPTY
        step(1'b1, 1'b1, 32'hEE, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);

        // Asynchronous reset mid-stream from TWO
        step(1'b0, 1'b1, 32'h33, 1'b0);
        step(1'b0, 1'b1, 32'h44, 1'b0);
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1;
        chk("pre_rst_occupancy", 32'(occupancy), 32'd2);
        rst = 1'b0;
        #1;
        check_reset();
        sb.delete();
        stall_m = 0;
        @(negedge clock);
        rst = 1'b1;

        // Stall counter saturation, unaffected by flush
        step(1'b0, 1'b1, 32'h55, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, 1'b0);
        chk("stall_sat", 32'(stall_cnt), 32'(CMAX));
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        chk("stall_after_flush", 32'(stall_cnt), 32'(CMAX));

        // Random protocol traffic
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)),
                 DATA_W'($urandom),
                 1'($urandom_range(0, 1)));
        end
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_stage.md
# pipe_skid_stage

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It generalises the fixed-field, write-enable stage registers in the CPU pipeline.
- Stall is driven by downstream back-pressure.
- Flush squashes the stage's contents.
- No combinational path runs from `out_ready` to `in_ready`.
- A saturating stall counter supports pipeline performance analysis.

Any stage boundary (IF/ID … MEM/WB) instantiates it with the concatenated stage payload.

## Interface
Parameters:
- `DATA_W`, default 32: payload width in bits (≥1).
- `CNT_W`, default 16: stall counter width in bits (≥1).

Ports:
- `clock`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-low reset.
- `flush`: input, 1 bit. Discards all held entries; takes effect at the next edge.
- `in_valid`: input, 1 bit. Upstream has a payload.
- `in_ready`: output, 1 bit. Stage can accept a payload.
- `in_data`: input, `DATA_W` bits. Upstream payload.
- `out_valid`: output, 1 bit. Stage presents a payload.
- `out_ready`: input, 1 bit. Downstream accepts the payload.
- `out_data`: output, `DATA_W` bits. Head payload.
- `occupancy`: output, 2 bits. Number of held entries, 0..2.
- `stall_cnt`: output, `CNT_W` bits. Cycles with `out_valid & ~out_ready`, saturating.

## Operation
Transfers:
- An input transfer occurs when `in_valid & in_ready`.
- An output transfer occurs when `out_valid & out_ready`.

Storage:
- Two registers: `main` (head) and `skid`.
- `out_data` = `main`.
- Entries leave in arrival order.

States are encoded in `occupancy`:
- **EMPTY (0)**
  - Input transfer → ONE, `main` ← `in_data`.
- **ONE (1)**
  - Input and output transfer → stay in ONE, `main` ← `in_data`.
  - Input transfer only → TWO, `skid` ← `in_data`.
  - Output transfer only → EMPTY.
  - Neither → hold.
- **TWO (2)**
  - `in_ready` = 0.
  - Output transfer → ONE, `main` ← `skid`.
  - Otherwise hold.

Output decode:
- `in_ready` = (state != TWO); it depends on registered state only.
- `out_valid` = (state != EMPTY).

Flush has priority over all transitions:
- Next state is EMPTY.
- An input transfer in the flush cycle is dropped; upstream sees the handshake complete.
- An output transfer in the flush cycle completes normally, because downstream already sampled it.

Stall counter:
- Increments by 1 on every edge where `out_valid & ~out_ready`.
- Holds at all-ones when it reaches all-ones; no wrap.
- Unaffected by `flush`.
- Cleared only by reset.

## Timing
- Latency from an input transfer to `out_valid` is 1 cycle.
- Throughput is 1 transfer per cycle when `out_ready` is continuously high.
- While `rst` = 0, regardless of `clock`, outputs are: `occupancy` = 0, `out_valid` = 0, `in_ready` = 1, `stall_cnt` = 0.
- `out_data` reset value depends on `PIPE_STAGE_DATA_CLR_EN` (see Configuration).
- Reset asserted mid-operation discards held entries immediately (asynchronous).
- On reset release, the first transfer can occur at the first following edge.
- Back-pressure, measured from the cycle `out_ready` drops with the stage in ONE and `in_valid` high:
  - One more input is accepted into `skid`.
  - `in_ready` falls the next cycle.
- `in_ready` rises in the cycle after the output transfer that leaves TWO.
- Simultaneous `flush` and `in_valid` in EMPTY: the stage stays EMPTY.

## Configuration
Macro: `PIPE_STAGE_DATA_CLR_EN`.

Defined:
- `main` and `skid` reset to 0.
- Both registers load 0 on `flush`.
- `out_data` = 0 whenever `occupancy` = 0 after reset or flush.

Undefined:
- Payload registers have no reset and are not cleared on flush; only state and counter are reset.
- `out_data` is don't-care while `out_valid` = 0.
- This saves area and reset fanout on wide payloads.

Both variants have identical handshake, ordering and counter behaviour.

## Test plan
1. **Reset value.** Hold `rst` = 0 mid-stream with `occupancy` = 2 → `out_valid`/`occupancy`/`stall_cnt` go to 0 and `in_ready` to 1 without waiting for a `clock` edge. With the macro defined, `out_data` = 0.
2. **Streaming.** `DATA_W` = 32, `out_ready` = 1, push 0x1…0x8 on consecutive cycles → same values appear one cycle later, in order, with no bubbles; `in_ready` stays 1.
3. **Back-pressure.** Push 0xA, 0xB, 0xC while `out_ready` = 0 → 0xA and 0xB are accepted, `occupancy` = 2, `in_ready` = 0, and 0xC is held upstream. Raise `out_ready` → outputs 0xA, 0xB, 0xC in order.
4. **Flush.** Flush in TWO with a concurrent `in_valid` → next cycle `occupancy` = 0 and `out_valid` = 0; the input is lost. With `out_ready` = 1 in the flush cycle, the head entry counts as delivered.
5. **Stall counter.** Set `CNT_W` = 4 and hold `out_valid` = 1, `out_ready` = 0 for 20 cycles → `stall_cnt` = 15 and holds. Then flush → `stall_cnt` stays at 15.
6. **Random protocol check.** Randomise `in_valid`/`out_ready`/`flush` for 10k cycles against a scoreboard → no loss, duplication or reordering outside flushes; `in_ready` never changes in response to same-cycle `out_ready`.
